// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, multiply/divide op encodings, MDU FSM states.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath on unsigned magnitudes.
// Multiply: {acc_hi, acc_lo} holds {partial product, remaining multiplier};
//           add the multiplicand when the multiplier LSB is set, then shift right.
// Divide:   {acc_hi, acc_lo} holds {partial remainder, dividend/quotient bits};
//           shift left, trial-subtract the divisor, keep it if it fits.
module mdu_step
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Single shift-add or restore-subtract step
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    // When the subtraction fits, the true difference is below the divisor,
    // so the low WIDTH bits carry the whole result.
    diff    = shifted[WIDTH-1:0] - operand;
    fits    = (shifted >= {1'b0, operand});
    hi_c    = sum[WIDTH:1];
    lo_c    = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      hi_c = fits ? diff : shifted[WIDTH-1:0];
      lo_c = {acc_lo[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional feature: define MDU_FLUSH_EN to add a flush input that aborts an
// in-flight operation without touching HI/LO.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
`ifdef MDU_FLUSH_EN
  input  logic             flush,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic               div_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               dz_q;
  logic [WIDTH-1:0]   raw_a_q;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   operand;

  mdu_op_e            op_e;
  logic               signed_op;
  logic               div_start;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               abort;

  // Operand decode, magnitudes and final sign correction
  always_comb begin
    op_e      = mdu_op_e'(op);
    signed_op = (op_e == MDU_MULT) || (op_e == MDU_DIV);
    div_start = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
    a_neg     = signed_op & src_a[WIDTH-1];
    b_neg     = signed_op & src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_q ? -prod : prod;
    quot_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix   = rem_neg_q ? -acc_hi : acc_hi;
  end

`ifdef MDU_FLUSH_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_q),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .hi_c    (step_hi),
    .lo_c    (step_lo)
  );

  // Control FSM, iteration counter, accumulators and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      raw_a_q   <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state     <= CALC;
            busy      <= 1'b1;
            cnt       <= '0;
            div_q     <= div_start;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= (src_b == '0);
            raw_a_q   <= src_a;
            acc_hi    <= '0;
            acc_lo    <= div_start ? a_mag : b_mag;
            operand   <= div_start ? b_mag : a_mag;
          end
        end
        CALC: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!abort) begin
            done <= 1'b1;
            if (!div_q) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (dz_q) begin
              hi       <= raw_a_q;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass;
  int n_total;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
`ifdef MDU_FLUSH_EN
    .flush    (flush),
`endif
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Launch one op; return cycles from start edge to done (0 on timeout).
  // inject_at > 0 pulses start/lo_we and changes src_a so they hit that edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output int lat,
                        output logic busy_bad, output logic hold_bad);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_bad = !busy; hold_bad = 1'b0;
    hi0 = hi; lo0 = lo;
    for (int i = 1; i <= 40; i++) begin
      if (i == inject_at) begin
        start = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; src_a = 32'd99;
      end
      @(posedge clk); #1;
      if (i == inject_at) begin
        start = 1'b0; lo_we = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_bad = 1'b1;
      if (hi !== hi0 || lo !== lo0) hold_bad = 1'b1;
    end
  endtask

  initial begin
    int          lat;
    logic        bb, hb, seen;
    logic [31:0] hs, ls;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // MULTU max x max
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bb, hb);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_busy_window", 64'(bb), 64'd0);
    check("multu_busy_drop", 64'(busy), 64'd0);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // MULT -7 x 3, then DIV -7 / 2 launched in the done cycle
    run_op(MDU_MULT, 32'hFFFF_FFF9, 32'd3, 0, lat, bb, hb);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_done", 64'(done), 64'd1);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, bb, hb);
    check("div_b2b_lat", 64'(lat), 64'd33);
    check("div_hold", 64'(hb), 64'd0);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIV 7 / -2 -> q=-3, r=1
    run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, 0, lat, bb, hb);
    check("div_negb_hilo", {hi, lo}, {32'd1, 32'hFFFF_FFFD});

    // DIVU 100 / 7 -> q=14, r=2
    run_op(MDU_DIVU, 32'd100, 32'd7, 0, lat, bb, hb);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    check("divu_dz_clear", 64'(div_zero), 64'd0);

    // Divide by zero
    run_op(MDU_DIVU, 32'd100, 32'd0, 0, lat, bb, hb);
    check("dz_hilo", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    check("dz_flag", 64'(div_zero), 64'd1);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd0, 0, lat, bb, hb);
    check("dz_signed_hilo", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    @(posedge clk); #1;
    check("dz_pulse_one", 64'({done, div_zero}), 64'd0);

    // Signed overflow
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bb, hb);
    check("ovf_hilo", {hi, lo}, {32'd0, 32'h8000_0000});
    check("ovf_no_dz", 64'(div_zero), 64'd0);

    // Start/lo_we/src_a change while busy are ignored
    run_op(MDU_MULTU, 32'd5, 32'd6, 10, lat, bb, hb);
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_hold", 64'(hb), 64'd0);
    check("ign_hilo", {hi, lo}, {32'd0, 32'd30});
    @(posedge clk); #1;
    check("ign_no_restart", 64'(busy), 64'd0);

    // MTHI in idle
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1; hi_we = 1'b0;
    check("mthi_hilo", {hi, lo}, {32'h1234_5678, 32'd30});
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo_both", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});

`ifdef MDU_FLUSH_EN
    // Flush mid-calculation
    @(negedge clk); op = MDU_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hilo", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});
`endif

    // Async reset mid-DIVU
    hs = hi; ls = lo;
    check("pre_reset_nonzero", 64'({hs, ls} != 64'd0), 64'd1);
    @(negedge clk); op = MDU_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    check("areset_busy_done", 64'({busy, done}), 64'd0);
    check("areset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
